cpu_state_scanner: RTL and testbench

Hardware debug scanner that sits directly upstream of the single-cycle CPU's debug read ports. On a start pulse it snapshots `cpu_pc`/`cpu_inst` and sweeps `rf_addr` over r1–r31 and `mem_addr` over a word window, one address at a time. Each value is captured and emitted as a tagged 32-bit record on a valid/ready stream, which feeds the board display/UART formatter. It replaces manual address stepping with a deterministic, back-pressurable dump of CPU state.

---
 rtl/cpu_state_scanner.sv | 134 +++++++++++++
 tb/tb_cpu_state_scanner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_scanner.sv
// cpu_state_scanner: snapshots PC/INST, then sweeps r1-r31 and a memory word window, emitting tagged records on a valid/ready stream; optional SCAN_CHECKSUM_EN appends an XOR checksum record
module cpu_state_scanner #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter int MEM_WORDS = 8,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rf_addr,
  output logic [31:0] mem_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_tag,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, SNAP_PC, SNAP_INST, SET, WAIT, CAPT, EMIT, FIN} state_t;
  state_t      state;
  logic [31:0] snap_inst;
  logic [5:0]  idx;
  logic        mem_phase;
  logic [3:0]  cnt;
  logic        hs;
  logic        last_mem;
`ifdef SCAN_CHECKSUM_EN
  logic [31:0] csum;
  logic        ck;
`endif
  assign hs = out_valid & out_ready;
  assign last_mem = mem_phase && idx == 6'(MEM_WORDS - 1);
  // scan sequencer; every output is a register written only here
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rf_addr   <= '0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      snap_inst <= '0;
      idx       <= '0;
      mem_phase <= 1'b0;
      cnt       <= '0;
`ifdef SCAN_CHECKSUM_EN
      csum      <= '0;
      ck        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          snap_inst <= cpu_inst;
          out_data  <= cpu_pc;
          out_tag   <= 8'h00;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          state     <= SNAP_PC;
`ifdef SCAN_CHECKSUM_EN
          csum      <= '0;
          ck        <= 1'b0;
`endif
        end
        SNAP_PC: if (hs) begin
          out_tag  <= 8'h01;
          out_data <= snap_inst;
          state    <= SNAP_INST;
`ifdef SCAN_CHECKSUM_EN
          csum     <= csum ^ out_data;
`endif
        end
        SNAP_INST: if (hs) begin
          out_valid <= 1'b0;
          idx       <= 6'd1;
          mem_phase <= 1'b0;
          state     <= SET;
`ifdef SCAN_CHECKSUM_EN
          csum      <= csum ^ out_data;
`endif
        end
        SET: begin
          if (mem_phase) mem_addr <= MEM_BASE + {24'd0, idx, 2'b00};
          else rf_addr <= idx[4:0];
          cnt   <= 4'(SETTLE - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == 4'd0) state <= CAPT; else cnt <= cnt - 4'd1;
        CAPT: begin
          out_data  <= mem_phase ? mem_data : rf_data;
          out_tag   <= mem_phase ? {2'b01, idx} : {3'b001, idx[4:0]};
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: if (hs) begin
          out_valid <= 1'b0;
          idx       <= idx + 6'd1;
          state     <= SET;
          if (!mem_phase && idx == 6'd31) begin
            mem_phase <= 1'b1;
            idx       <= '0;
          end
`ifdef SCAN_CHECKSUM_EN
          csum <= csum ^ out_data;
          if (ck) state <= FIN;
          else if (last_mem) begin
            out_valid <= 1'b1;
            out_tag   <= 8'hFF;
            out_data  <= csum ^ out_data;
            ck        <= 1'b1;
            state     <= EMIT;
          end
`else
          if (last_mem) state <= FIN;
`endif
        end
        FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          rf_addr  <= '0;
          mem_addr <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_state_scanner.sv
// tb_cpu_state_scanner: directed bench for cpu_state_scanner with a CPU read model and a stream monitor
module tb_cpu_state_scanner;
`ifdef SCAN_CHECKSUM_EN
  localparam int NREC = 42;
  localparam int LAT = 160;
`else
  localparam int NREC = 41;
  localparam int LAT = 159;
`endif
  logic clk = 1'b0, reset, start, out_ready, out_valid, busy, done;
  logic [4:0] rf_addr;
  logic [31:0] mem_addr, rf_data, mem_data, cpu_pc, cpu_inst, out_data;
  logic [7:0] out_tag;
  int checks = 0, failures = 0, done_cnt = 0, cyc;
  logic [7:0] tq[$];
  logic [31:0] dq[$];
  logic [7:0] held_tag;
  logic [31:0] held_data;

  cpu_state_scanner dut (
    .clk(clk), .reset(reset), .start(start), .rf_addr(rf_addr), .mem_addr(mem_addr),
    .rf_data(rf_data), .mem_data(mem_data), .cpu_pc(cpu_pc), .cpu_inst(cpu_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rf_data = 32'h1000_0000 + {27'd0, rf_addr};
  assign mem_data = ~mem_addr;

  always @(negedge clk) if (!reset) begin
    if (out_valid && out_ready) begin
      tq.push_back(out_tag);
      dq.push_back(out_data);
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  function automatic logic [7:0] exp_tag(input int i);
    return i == 0 ? 8'h00 : i == 1 ? 8'h01 : i < 33 ? 8'(32'h20 + i - 1) : 8'(32'h40 + i - 33);
  endfunction

  function automatic logic [31:0] exp_data(input int i, input logic [31:0] pc, input logic [31:0] inst);
    return i == 0 ? pc : i == 1 ? inst : i < 33 ? 32'h1000_0000 + 32'(i - 1) : ~(32'(4 * (i - 33)));
  endfunction

  task automatic check_scan(input logic [31:0] pc, input logic [31:0] inst);
    logic [31:0] x;
    chk("rec_count", 64'(tq.size()), 64'(NREC));
    if (tq.size() == NREC) begin
      x = '0;
      for (int i = 0; i < 41; i++) begin
        chk($sformatf("tag%0d", i), 64'(tq[i]), 64'(exp_tag(i)));
        chk($sformatf("data%0d", i), 64'(dq[i]), 64'(exp_data(i, pc, inst)));
        x ^= dq[i];
      end
`ifdef SCAN_CHECKSUM_EN
      chk("csum_tag", 64'(tq[41]), 64'hFF);
      chk("csum_data", 64'(dq[41]), 64'(x));
`endif
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    cpu_pc = 32'h0000_0010; cpu_inst = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk("rst_rf_addr", 64'(rf_addr), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();
    // full scan, snapshot, ignored start while busy
    tq.delete(); dq.delete(); done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0; cpu_pc = 32'h0000_0014;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_valid", 64'(out_valid), 64'd1);
    chk("start_tag", 64'(out_tag), 64'h00);
    chk("start_pc", 64'(out_data), 64'h10);
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    chk("done_latency", 64'(cyc + 21), 64'(LAT));
    chk("fin_busy", 64'(busy), 64'd0);
    chk("fin_rf_addr", 64'(rf_addr), 64'd0);
    repeat (5) tick();
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    check_scan(32'h0000_0010, 32'hDEAD_BEEF);
    // back-pressure on tag 2A
    tq.delete(); dq.delete(); done_cnt = 0;
    cpu_pc = 32'h0000_0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_tag == 8'h2A) && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("bp_found", 64'(out_tag), 64'h2A);
    out_ready = 1'b0;
    held_tag = out_tag; held_data = out_data;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_tag", 64'(out_tag), 64'(held_tag));
      chk("bp_data", 64'(out_data), 64'(held_data));
      chk("bp_rf_addr", 64'(rf_addr), 64'd10);
    end
    chk("bp_data_val", 64'(held_data), 64'h1000_000A);
    out_ready = 1'b1;
    wait_done(cyc);
    tick();
    check_scan(32'h0000_0100, 32'hDEAD_BEEF);
    chk("bp_done_once", 64'(done_cnt), 64'd1);
    // reset mid-scan after tag 25 is accepted
    tq.delete(); dq.delete(); done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_tag == 8'h25) && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("mid_found", 64'(out_tag), 64'h25);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_rf_addr", 64'(rf_addr), 64'd0);
    chk("mid_tag", 64'(out_tag), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    reset = 1'b0;
    tq.delete(); dq.delete(); done_cnt = 0;
    cpu_pc = 32'h0000_0200; cpu_inst = 32'h1234_5678;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_tag", 64'(out_tag), 64'h00);
    chk("restart_valid", 64'(out_valid), 64'd1);
    wait_done(cyc);
    tick();
    check_scan(32'h0000_0200, 32'h1234_5678);
    chk("restart_done_once", 64'(done_cnt), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
